// File: rtl/decode_queue.sv
// decode_queue: multi-wide MIPS32 decode-on-enqueue instruction queue between fetch and issue.
// Words are decoded as they are written; issue sees the oldest ISSUE_WIDTH entries.
package decode_queue_pkg;
    typedef enum logic [5:0] {
        NOP, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR, SYSCALL, BREAK,
        MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU,
        ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU,
        BLTZ, BGEZ, BLTZAL, BGEZAL, J, JAL, BEQ, BNE, BLEZ, BGTZ,
        ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI,
        MFC0, MTC0, ERET,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        DECODE_ERROR
    } op_t;

    function automatic op_t decode(input logic [31:0] w);
        op_t op;
        op = DECODE_ERROR;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h00: op = (w[15:11] == 5'd0) ? NOP : SLL;
                6'h02: op = SRL;
                6'h03: op = SRA;
                6'h04: op = SLLV;
                6'h06: op = SRLV;
                6'h07: op = SRAV;
                6'h08: op = JR;
                6'h09: op = JALR;
                6'h0c: op = SYSCALL;
                6'h0d: op = BREAK;
                6'h10: op = MFHI;
                6'h11: op = MTHI;
                6'h12: op = MFLO;
                6'h13: op = MTLO;
                6'h18: op = MULT;
                6'h19: op = MULTU;
                6'h1a: op = DIV;
                6'h1b: op = DIVU;
                6'h20: op = ADD;
                6'h21: op = ADDU;
                6'h22: op = SUB;
                6'h23: op = SUBU;
                6'h24: op = AND;
                6'h25: op = OR;
                6'h26: op = XOR;
                6'h27: op = NOR;
                6'h2a: op = SLT;
                6'h2b: op = SLTU;
                default: op = DECODE_ERROR;
            endcase
            6'h01: case (w[20:16])
                5'h00: op = BLTZ;
                5'h01: op = BGEZ;
                5'h10: op = BLTZAL;
                5'h11: op = BGEZAL;
                default: op = DECODE_ERROR;
            endcase
            6'h02: op = J;
            6'h03: op = JAL;
            6'h04: op = BEQ;
            6'h05: op = BNE;
            6'h06: op = BLEZ;
            6'h07: op = BGTZ;
            6'h08: op = ADDI;
            6'h09: op = ADDIU;
            6'h0a: op = SLTI;
            6'h0b: op = SLTIU;
            6'h0c: op = ANDI;
            6'h0d: op = ORI;
            6'h0e: op = XORI;
            6'h0f: op = LUI;
            6'h10: op = (w[25:21] == 5'd0) ? MFC0 :
                        (w[25:21] == 5'd4) ? MTC0 :
                        (w[25] && w[24:6] == 19'd0) ? ERET : DECODE_ERROR;
            6'h20: op = LB;
            6'h21: op = LH;
            6'h23: op = LW;
            6'h24: op = LBU;
            6'h25: op = LHU;
            6'h28: op = SB;
            6'h29: op = SH;
            6'h2b: op = SW;
            default: op = DECODE_ERROR;
        endcase
        return op;
    endfunction

    function automatic logic is_ctl(input op_t op);
        return op inside {J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL};
    endfunction
endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]      in_count,
    input  logic [31:0]                           in_pc,
    input  logic [32*FETCH_WIDTH-1:0]             in_instr,
    output logic [ISSUE_WIDTH-1:0]                out_valid,
    output logic [ISSUE_WIDTH*$bits(op_t)-1:0]    out_op,
    output logic [32*ISSUE_WIDTH-1:0]             out_pc,
    output logic [32*ISSUE_WIDTH-1:0]             out_instr,
    output logic [ISSUE_WIDTH-1:0]                out_ri,
    output logic [ISSUE_WIDTH-1:0]                out_ds,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]      out_take
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(FETCH_WIDTH+1);
    localparam int OW = $bits(op_t);

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          ds_pending;

    logic [OW-1:0] m_op    [DEPTH];
    logic [31:0]   m_pc    [DEPTH];
    logic [31:0]   m_instr [DEPTH];
    logic [DEPTH-1:0] m_ds;

    op_t              l_op [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] l_ctl, l_ds;
    logic             last_ctl, prev, enq;
    logic [IW-1:0]    enq_n;

    assign in_ready = (CW'(DEPTH) - count) >= CW'(FETCH_WIDTH);
    assign enq      = in_valid && in_ready && !flush;
    assign enq_n    = enq ? in_count : '0;

    // Delay-slot flag ripples lane to lane, seeded by the last word of the previous group.
    always_comb begin
        prev     = ds_pending;
        last_ctl = ds_pending;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            l_op[i]  = decode(in_instr[32*i +: 32]);
            l_ctl[i] = is_ctl(l_op[i]);
            l_ds[i]  = prev;
            prev     = l_ctl[i];
            last_ctl = (i < int'(in_count)) ? l_ctl[i] : last_ctl;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ds_pending <= 1'b0;
        end else if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ds_pending <= 1'b0;
        end else begin
            head       <= head + PW'(out_take);
            tail       <= tail + PW'(enq_n);
            count      <= count + CW'(enq_n) - CW'(out_take);
            ds_pending <= enq ? last_ctl : ds_pending;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (enq && i < int'(in_count)) begin
                m_op[tail + PW'(i)]    <= l_op[i];
                m_pc[tail + PW'(i)]    <= in_pc + 32'(4 * i);
                m_instr[tail + PW'(i)] <= in_instr[32*i +: 32];
                m_ds[tail + PW'(i)]    <= l_ds[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && !flush)
            assert (int'(out_take) <= ((int'(count) > ISSUE_WIDTH) ? ISSUE_WIDTH : int'(count)))
            else $error("decode_queue: out_take %0d exceeds valid entries", out_take);
    end

    always_comb begin
        logic [PW-1:0] idx;
        logic          v;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            idx                    = head + PW'(i);
            v                      = i < int'(count);
            out_valid[i]           = v;
            out_op[OW*i +: OW]     = v ? m_op[idx] : '0;
            out_pc[32*i +: 32]     = v ? m_pc[idx] : '0;
            out_instr[32*i +: 32]  = v ? m_instr[idx] : '0;
            out_ri[i]              = v && (m_op[idx] == DECODE_ERROR);
            out_ds[i]              = v && m_ds[idx];
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed scenario tests for decode_queue with hand-computed expectations.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready;
    logic [1:0]  in_count, out_take;
    logic [31:0] in_pc;
    logic [63:0] in_instr;
    logic [1:0]  out_valid, out_ri, out_ds;
    logic [11:0] out_op;
    logic [63:0] out_pc, out_instr;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] W_BEQ   = 32'h1000FFFF;
    localparam logic [31:0] W_ADDIU = 32'h24020001;
    localparam logic [31:0] W_JAL   = 32'h0C000010;

    decode_queue dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_count(in_count), .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid),
        .out_op(out_op), .out_pc(out_pc), .out_instr(out_instr), .out_ri(out_ri),
        .out_ds(out_ds), .out_take(out_take)
    );

    always #5 clk = ~clk;

    task automatic cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [1:0] c, input logic [31:0] pc,
                       input logic [63:0] ins, input logic [1:0] t, input logic f);
        in_valid = v;
        in_count = c;
        in_pc    = pc;
        in_instr = ins;
        out_take = t;
        flush    = f;
    endtask

    task automatic step(input logic v, input logic [1:0] c, input logic [31:0] pc,
                        input logic [63:0] ins, input logic [1:0] t, input logic f);
        drv(v, c, pc, ins, t, f);
        cycle();
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b exp 00", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
        checks++; if (out_pc !== 64'd0 || out_op !== 12'd0) begin errors++; $display("FAIL reset_data: pc %h op %h exp 0", out_pc, out_op); end
        resetn = 1'b1;
        cycle();
    endtask

    task automatic test_single;
        drv(1, 1, 32'hBFC00000, {32'hFC000000, 32'h00000000}, 0, 0);
        #1;
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL no_comb_path: got %b exp 00", out_valid); end
        cycle();
        checks++; if (out_valid !== 2'b01) begin errors++; $display("FAIL single_valid: got %b exp 01", out_valid); end
        checks++; if (out_op[5:0] !== NOP || out_ri !== 2'b00 || out_ds !== 2'b00) begin errors++; $display("FAIL single_decode: op %0d ri %b ds %b exp op %0d ri 00 ds 00", out_op[5:0], out_ri, out_ds, NOP); end
        checks++; if (out_pc !== {32'h0, 32'hBFC00000}) begin errors++; $display("FAIL single_pc: got %h exp 00000000bfc00000", out_pc); end
        step(0, 0, 0, 0, 1, 0);
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL single_drain: got %b exp 00", out_valid); end
    endtask

    task automatic test_delay_slot;
        step(1, 1, 32'h100, {32'h0, W_BEQ}, 0, 0);
        step(1, 1, 32'h104, {32'h0, W_ADDIU}, 0, 0);
        checks++; if (out_op !== {6'(ADDIU), 6'(BEQ)} || out_ds !== 2'b10) begin errors++; $display("FAIL ds_cross: op %h ds %b exp op %h ds 10", out_op, out_ds, {6'(ADDIU), 6'(BEQ)}); end
        checks++; if (out_pc !== {32'h104, 32'h100}) begin errors++; $display("FAIL ds_cross_pc: got %h exp 0000010400000100", out_pc); end
        step(0, 0, 0, 0, 2, 0);
        step(1, 2, 32'h200, {32'h00000000, W_JAL}, 0, 0);
        checks++; if (out_op !== {6'(NOP), 6'(JAL)} || out_ds !== 2'b10) begin errors++; $display("FAIL ds_group: op %h ds %b exp op %h ds 10", out_op, out_ds, {6'(NOP), 6'(JAL)}); end
        checks++; if (out_pc !== {32'h204, 32'h200}) begin errors++; $display("FAIL ds_group_pc: got %h exp 0000020400000200", out_pc); end
        step(0, 0, 0, 0, 2, 0);
        step(1, 1, 32'h300, {32'h0, W_BEQ}, 0, 0);
        step(1, 0, 32'h900, {W_ADDIU, W_ADDIU}, 1, 0);
        step(1, 1, 32'h304, {32'h0, W_ADDIU}, 0, 0);
        checks++; if (out_valid !== 2'b01 || out_op[5:0] !== ADDIU || out_ds !== 2'b01) begin errors++; $display("FAIL ds_count0: valid %b op %0d ds %b exp valid 01 op %0d ds 01", out_valid, out_op[5:0], out_ds, ADDIU); end
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_reserved;
        step(1, 2, 32'h400, {32'h40400000, 32'hFC000000}, 0, 0);
        checks++; if (out_op !== {6'(DECODE_ERROR), 6'(DECODE_ERROR)} || out_ri !== 2'b11) begin errors++; $display("FAIL ri_decode: op %h ri %b exp op %h ri 11", out_op, out_ri, {6'(DECODE_ERROR), 6'(DECODE_ERROR)}); end
        checks++; if (out_instr !== {32'h40400000, 32'hFC000000}) begin errors++; $display("FAIL ri_instr: got %h exp 40400000fc000000", out_instr); end
        step(1, 1, 32'h408, {32'h0, 32'h42000018}, 2, 0);
        checks++; if (out_valid !== 2'b01 || out_op[5:0] !== ERET || out_ri !== 2'b00) begin errors++; $display("FAIL eret: valid %b op %0d ri %b exp valid 01 op %0d ri 00", out_valid, out_op[5:0], out_ri, ERET); end
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_full;
        step(1, 2, 32'h1000, {W_ADDIU, W_ADDIU}, 0, 0);
        step(1, 2, 32'h1008, {W_ADDIU, W_ADDIU}, 0, 0);
        step(1, 2, 32'h1010, {W_ADDIU, W_ADDIU}, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready6: got %b exp 1", in_ready); end
        step(1, 2, 32'h1018, {W_ADDIU, W_ADDIU}, 0, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready8: got %b exp 0", in_ready); end
        step(1, 2, 32'h2000, {W_ADDIU, W_ADDIU}, 0, 0);
        checks++; if (in_ready !== 1'b0 || out_pc !== {32'h1004, 32'h1000}) begin errors++; $display("FAIL full_hold: ready %b pc %h exp ready 0 pc 0000100400001000", in_ready, out_pc); end
        step(1, 2, 32'h2000, {W_ADDIU, W_ADDIU}, 2, 0);
        checks++; if (in_ready !== 1'b1 || out_pc !== {32'h100C, 32'h1008}) begin errors++; $display("FAIL full_take: ready %b pc %h exp ready 1 pc 0000100c00001008", in_ready, out_pc); end
        step(0, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0, 2, 0);
        checks++; if (out_pc !== {32'h101C, 32'h1018}) begin errors++; $display("FAIL full_order: got %h exp 0000101c00001018", out_pc); end
        step(0, 0, 0, 0, 2, 0);
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL full_empty: got %b exp 00", out_valid); end
    endtask

    task automatic test_wrap;
        logic [31:0] pc;
        pc = 32'h4000;
        step(1, 2, pc, {W_ADDIU, W_ADDIU}, 0, 0);
        for (int k = 0; k < 20; k++) begin
            checks++; if (out_valid !== 2'b11 || out_pc !== {pc + 32'd4, pc}) begin errors++; $display("FAIL wrap_%0d: valid %b pc %h exp valid 11 pc %h", k, out_valid, out_pc, {pc + 32'd4, pc}); end
            pc = pc + 32'd8;
            step(1, 2, pc, {W_ADDIU, W_ADDIU}, 2, 0);
        end
        checks++; if (out_pc !== {pc + 32'd4, pc}) begin errors++; $display("FAIL wrap_last: got %h exp %h", out_pc, {pc + 32'd4, pc}); end
        step(0, 0, 0, 0, 2, 0);
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL wrap_empty: got %b exp 00", out_valid); end
    endtask

    task automatic test_flush;
        step(1, 2, 32'h500, {W_ADDIU, W_ADDIU}, 0, 0);
        step(1, 2, 32'h508, {W_ADDIU, W_ADDIU}, 0, 0);
        step(1, 1, 32'h510, {32'h0, W_BEQ}, 0, 0);
        step(1, 2, 32'h514, {W_ADDIU, W_ADDIU}, 1, 1);
        checks++; if (out_valid !== 2'b00 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: valid %b ready %b exp valid 00 ready 1", out_valid, in_ready); end
        step(1, 1, 32'h600, {32'h0, W_ADDIU}, 0, 0);
        checks++; if (out_valid !== 2'b01 || out_ds !== 2'b00 || out_pc[31:0] !== 32'h600) begin errors++; $display("FAIL flush_ds: valid %b ds %b pc %h exp valid 01 ds 00 pc 00000600", out_valid, out_ds, out_pc[31:0]); end
    endtask

    task automatic test_async_reset;
        step(1, 2, 32'h700, {W_ADDIU, W_ADDIU}, 0, 0);
        drv(1, 2, 32'h708, {W_ADDIU, W_ADDIU}, 0, 0);
        #3 resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 2'b00 || out_pc !== 64'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset: valid %b pc %h ready %b exp 00 0 1", out_valid, out_pc, in_ready); end
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        cycle();
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL post_reset: got %b exp 00", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_delay_slot();
        test_reserved();
        test_full();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Instruction buffer between fetch and issue that decodes on enqueue.
- Accepts up to FETCH_WIDTH fetched MIPS32 words per cycle. Each word is decoded into op_t plus a reserved-instruction flag and a delay-slot flag, then stored in a circular queue.
- Presents the oldest ISSUE_WIDTH decoded entries to issue.
- Generalises the single-word combinational decoder to multi-wide, buffered, flushable decode with delay-slot tracking.

Parameters:
- FETCH_WIDTH, 2, words accepted per cycle (1..4).
- ISSUE_WIDTH, 2, entries presented per cycle (1..4).
- DEPTH, 8, queue entries; power of two, and DEPTH >= FETCH_WIDTH + ISSUE_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries (exception/redirect).
- in_valid  in  1  fetch group valid.
- in_ready  out  1  queue can accept a full group.
- in_count  in  $clog2(FETCH_WIDTH+1)  valid words in group, lane 0 first; 1..FETCH_WIDTH when in_valid.
- in_pc  in  32  PC of lane 0; lane i PC = in_pc + 4*i.
- in_instr  in  32*FETCH_WIDTH  instruction words, lane i at [32i+31:32i].
- out_valid  out  ISSUE_WIDTH  lane i holds the i-th oldest entry; thermometer-coded (lane i valid implies lane i-1 valid).
- out_op  out  ISSUE_WIDTH x op_t  decoded op per lane.
- out_pc  out  32*ISSUE_WIDTH  PC per lane.
- out_instr  out  32*ISSUE_WIDTH  raw word per lane (immediates, register fields).
- out_ri  out  ISSUE_WIDTH  reserved instruction (op == DECODE_ERROR).
- out_ds  out  ISSUE_WIDTH  entry is in a branch/jump delay slot.
- out_take  in  $clog2(ISSUE_WIDTH+1)  entries consumed this cycle, oldest first; must not exceed popcount(out_valid).

Behaviour:
- Reset (async assert, sync deassert release): head = tail = count = 0, ds_pending = 0. Consequently out_valid = 0 and in_ready = 1. All out_* data lanes drive 0 when invalid, including after reset.
- Decode mapping per lane, identical to the existing op table:
  - R-type by funct; SLL with rd == 0 is NOP.
  - REGIMM by rt.
  - COP0 by rs: MFC0 / MTC0 / ERET (rs[4] set and instr[24:6] == 0).
  - Loads/stores and immediate ops by opcode.
  - Anything else is DECODE_ERROR with ri = 1.
- Control ops: J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL.
- Delay slot: lane i's ds = 1 iff the previous enqueued word is a control op. For lane 0, "previous" is ds_pending, which holds that information across cycles. ds_pending updates to the control-op status of the last accepted lane (in_count-1).
- A control op that is itself in a delay slot still sets ds for the following word; no nesting check.
- Enqueue occurs when in_valid && in_ready && !flush:
  - write in_count entries at tail..tail+in_count-1, modulo DEPTH;
  - tail += in_count.
- in_ready = (DEPTH - count) >= FETCH_WIDTH, computed from the registered count only. It does not consider same-cycle dequeue and is purely combinational from state.
- Latency: a word accepted in cycle N appears on out_* in cycle N+1 at the earliest. There is no combinational in→out path.
- Dequeue: head += out_take; count updates as count + enq - out_take in the same cycle (simultaneous enqueue and dequeue is legal).
- Output lane i shows entry head+i (mod DEPTH); out_valid[i] = (i < count).
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. A group straddling index DEPTH-1 → 0 is written correctly.
- flush: next cycle count = 0, head = tail = 0, ds_pending = 0. Flush overrides both enqueue and out_take in the same cycle.
- out_take > popcount(out_valid) is illegal. The design must assert in simulation; hardware behaviour is undefined.
- in_count = 0 with in_valid = 1 is legal, a no-op, and does not change ds_pending.

Test Plan:
- Reset then single word: in_count=1, in_pc=0xBFC00000, instr 0x00000000 → next cycle out_valid=01, op=NOP, ri=0, ds=0, pc=0xBFC00000.
- Cross-cycle delay slot: cycle 0 enqueue 0x1000FFFF (BEQ); cycle 1 enqueue 0x24020001 (ADDIU) → entries BEQ ds=0, ADDIU ds=1. In-group: lanes {0x0C000010 JAL, 0x00000000} → lane1 ds=1.
- Reserved instruction: 0xFC000000 and 0x4040_0000 (COP0 rs=2) → op=DECODE_ERROR, ri=1. 0x42000018 → ERET, ri=0.
- Full/backpressure with DEPTH=8, FETCH_WIDTH=2, out_take=0: enqueue 2 per cycle. After 3 groups count=6 and in_ready=1; after the 4th count=8 and in_ready=0. Then out_take=2 → in_ready=1 next cycle.
- Wrap and simultaneous events: steady enqueue 2 / take 2 over 20 cycles → PCs leave strictly increasing by 4, with no loss or duplication across the index 7→0 wrap.
- Flush and reset mid-operation: with count=5, assert flush together with in_valid and out_take=1 → next cycle out_valid=0, count=0, and the next enqueue sees ds=0. Assert resetn=0 mid-burst → outputs clear immediately (asynchronous), before the next clk edge.
